// File: rtl/hmac_job_arbiter_if.sv
// Core-side HMAC port of secure_key_system as seen by the job arbiter.
// The arbiter is the master: it starts jobs and streams message words;
// the core answers with ready, the digest and a done pulse.
interface hmac_job_arbiter_if;
   logic         hmac_start;
   logic [31:0]  hmac_word;
   logic         hmac_valid;
   logic         hmac_last;
   logic         hmac_ready;
   logic [511:0] hmac_value;
   logic         hmac_done;

   modport master (
      output hmac_start,
      output hmac_word,
      output hmac_valid,
      output hmac_last,
      input  hmac_ready,
      input  hmac_value,
      input  hmac_done
   );

   modport slave (
      input  hmac_start,
      input  hmac_word,
      input  hmac_valid,
      input  hmac_last,
      output hmac_ready,
      output hmac_value,
      output hmac_done
   );
endinterface

// File: rtl/hmac_job_arbiter.sv
// Round-robin arbiter sharing the single HMAC port of secure_key_system
// between NUM_REQ requesters. One job at a time: grant, start pulse,
// stream the owner's words, wait for the digest (with a watchdog), hand
// the result back, release. New jobs are only granted while the PUF key
// is valid; a job already running is never aborted by key or req changes.
module hmac_job_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  key_valid,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*32-1:0] req_word,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_last,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    grant,
   output logic [NUM_REQ-1:0]    job_done,
   output logic [NUM_REQ-1:0]    job_error,
   output logic [511:0]          result,
   output logic                  busy,
   hmac_job_arbiter_if.master    core
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REQ - 1);
   localparam logic [TMR_W-1:0]   TIMER_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      STREAM    = 3'd2,
      WAIT_DONE = 3'd3,
      RELEASE   = 3'd4
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] rr_ptr;
   logic [TMR_W-1:0] timer;

   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic             xfer;
   logic [IDX_W-1:0] rr_next;

   // Round-robin search: first pending request at or after rr_ptr, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = {IDX_W{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!pick_found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         end else begin
            pick_found = pick_found;
         end
      end
   end

   // Pointer value that gives the requester after the current owner priority.
   always_comb begin
      if (owner == LAST_IDX) begin
         rr_next = {IDX_W{1'b0}};
      end else begin
         rr_next = owner + IDX_W'(1);
      end
   end

   // Forward the owner's stream to the core; everything idles outside STREAM.
   always_comb begin
      core.hmac_word  = 32'd0;
      core.hmac_valid = 1'b0;
      core.hmac_last  = 1'b0;
      req_ready       = {NUM_REQ{1'b0}};
      if (state == STREAM) begin
         core.hmac_word   = req_word[32*int'(owner) +: 32];
         core.hmac_valid  = req_valid[owner];
         core.hmac_last   = req_last[owner];
         req_ready[owner] = core.hmac_ready;
      end else begin
         req_ready = {NUM_REQ{1'b0}};
      end
   end

   assign xfer = core.hmac_valid && core.hmac_ready;

   // Job sequencer with registered grant, pulses, digest and watchdog timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         owner           <= {IDX_W{1'b0}};
         rr_ptr          <= {IDX_W{1'b0}};
         timer           <= {TMR_W{1'b0}};
         grant           <= {NUM_REQ{1'b0}};
         job_done        <= {NUM_REQ{1'b0}};
         job_error       <= {NUM_REQ{1'b0}};
         result          <= 512'd0;
         busy            <= 1'b0;
         core.hmac_start <= 1'b0;
      end else begin
         job_done        <= {NUM_REQ{1'b0}};
         job_error       <= {NUM_REQ{1'b0}};
         core.hmac_start <= 1'b0;
         case (state)
            IDLE: begin
               if (key_valid && pick_found) begin
                  owner           <= pick_idx;
                  grant           <= ONE_HOT0 << pick_idx;
                  core.hmac_start <= 1'b1;
                  busy            <= 1'b1;
                  state           <= START;
               end else begin
                  state <= IDLE;
               end
            end
            START: begin
               state <= STREAM;
            end
            STREAM: begin
               if (xfer && core.hmac_last) begin
                  timer <= {TMR_W{1'b0}};
                  state <= WAIT_DONE;
               end else begin
                  state <= STREAM;
               end
            end
            WAIT_DONE: begin
               timer <= timer + TMR_W'(1);
               // A digest arriving on the timeout cycle still counts as success.
               if (core.hmac_done) begin
                  result   <= core.hmac_value;
                  job_done <= grant;
                  state    <= RELEASE;
               end else if (timer == TIMER_LAST) begin
                  job_error <= grant;
                  state     <= RELEASE;
               end else begin
                  state <= WAIT_DONE;
               end
            end
            RELEASE: begin
               grant  <= {NUM_REQ{1'b0}};
               rr_ptr <= rr_next;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               grant <= {NUM_REQ{1'b0}};
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/hmac_job_arbiter.md
Name: hmac_job_arbiter

Overview:
- Shares the single HMAC port of secure_key_system (start_hmac / msg_word / msg_valid / msg_last / msg_ready / hmac_value / hmac_done) between NUM_REQ independent requesters.
- Grants one HMAC job at a time, round-robin, and only once puf_key_valid is high.
- Streams the owner's message words to the core, then captures the 512-bit result and returns it to the owner with a done pulse.
- A watchdog aborts jobs whose digest never arrives.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 4096, maximum cycles spent in WAIT_DONE before abort (≥ 2).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- key_valid  in  1  puf_key_valid from secure_key_system
- req  in  NUM_REQ  job request per requester; level, held until grant
- req_word  in  NUM_REQ*32  message word per requester; slice i = bits [32i+31:32i]
- req_valid  in  NUM_REQ  word valid per requester
- req_last  in  NUM_REQ  final word of message
- req_ready  out  NUM_REQ  word accepted (owner only)
- grant  out  NUM_REQ  one-hot owner of current job, registered
- job_done  out  NUM_REQ  one-cycle pulse to owner on result
- job_error  out  NUM_REQ  one-cycle pulse to owner on timeout
- result  out  512  last captured digest, held
- busy  out  1  high in any state other than IDLE
- hmac_start  out  1  to core start_hmac, registered one-cycle pulse
- hmac_word  out  32  to core msg_word
- hmac_valid  out  1  to core msg_valid
- hmac_last  out  1  to core msg_last
- hmac_ready  in  1  core msg_ready
- hmac_value  in  512  core digest
- hmac_done  in  1  core done pulse

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All registered outputs change only on the rising edge of clk.
- Reset values: grant=0, job_done=0, job_error=0, result=0, busy=0, hmac_start=0, rr_ptr=0, timer=0, state=IDLE. Combinational outputs are 0 while state≠STREAM.
- Reset mid-job: the core is not notified. Arbiter returns to IDLE; software must reset the core too.
- IDLE:
  - If key_valid && |req, pick the first set req bit searching from index rr_ptr upward, wrapping modulo NUM_REQ.
  - Register grant = one-hot of the winner. hmac_start=1 on the same edge. Go to START.
  - If key_valid is low, req is ignored and no grant is issued.
- START: hmac_start returns to 0 (exactly one cycle wide). Go to STREAM.
- STREAM (combinational forwarding):
  - hmac_word = req_word[owner], hmac_valid = req_valid[owner], hmac_last = req_last[owner].
  - req_ready[owner] = hmac_ready; req_ready of all other requesters = 0.
  - A word transfers when hmac_valid && hmac_ready.
  - On a transfer with hmac_last=1, go to WAIT_DONE and clear timer.
- WAIT_DONE:
  - timer increments each cycle.
  - On hmac_done: result ← hmac_value; job_done[owner]=1 next cycle; go to RELEASE.
  - Else if timer == TIMEOUT_CYCLES-1: job_error[owner]=1; result unchanged; go to RELEASE.
  - hmac_done and timeout in the same cycle: hmac_done wins.
- RELEASE:
  - grant ← 0; rr_ptr ← (owner+1) mod NUM_REQ; return to IDLE.
  - IDLE may grant again on the next cycle, so back-to-back jobs have 3 idle-side cycles overhead.
- Ignored events:
  - hmac_done outside WAIT_DONE is ignored.
  - Owner dropping req mid-job does not abort; the job runs until last word and digest.
  - key_valid falling mid-job does not abort the current job; it only blocks new grants.
- Latency: req sampled at edge t yields grant and hmac_start at t+1; job_done rises one cycle after the hmac_done edge.

Test Plan:
- Key gating: key_valid=0, req=4'b0001 for 20 cycles → grant stays 0, hmac_start never pulses. Raise key_valid → grant=4'b0001 and hmac_start=1 for one cycle on the next edge.
- Single-word job: req[2] with word 0x12345678, last=1 → core sees one transfer 0x12345678/last=1. Model hmac_done with value 512'hA5…A5 → result=A5…A5, job_done=4'b0100 for one cycle, busy falls two cycles later.
- Round-robin fairness: req=4'b1111 held with single-word jobs → grant order 0,1,2,3,0. Then rr_ptr=2 with req=4'b0011 → next grant is requester 0.
- Multi-word and isolation: owner 1 sends 0xDEADBEEF, 0xCAFEBABE(last) while requester 3 asserts req_valid → req_ready[3] stays 0. Core hmac_ready toggling 1,0,1 → exactly 2 transfers, in order.
- Timeout: TIMEOUT_CYCLES=16, no hmac_done → job_error[owner] pulses 16 cycles after the last-word transfer, result unchanged, next requester granted. Same test with hmac_done on cycle 16 → job_done, not job_error.
- Reset mid-STREAM: assert reset after one of three words → all outputs at reset values next edge, rr_ptr=0. After reset, the first grant goes to the lowest pending request.
